// File: rtl/train_pkg.sv
// Shared types and constants for the Train feeder stage.
package train_pkg;

  localparam int CAR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    SEND,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK  = 2'd0,
    ERR_CNT = 2'd1,
    ERR_ORD = 2'd2,
    ERR_TMO = 2'd3
  } err_t;

endpackage

// File: rtl/train_order_chk.sv
// Order buffer with used-mask: stores car ids by index and flags zero, out-of-range or repeated ids.
module train_order_chk
  import train_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [CAR_W-1:0] i_wr_idx,
  input  logic [CAR_W-1:0] i_wr_data,
  input  logic [CAR_W-1:0] i_n,
  input  logic [CAR_W-1:0] i_rd_idx,
  output logic [CAR_W-1:0] o_rd_data,
  output logic             o_bad
);

  logic [CAR_W-1:0] r_buf [16];
  logic [15:0]      r_used;
  logic             r_bad;
  logic             w_bad_beat;

  assign w_bad_beat = (i_wr_data == '0) || (i_wr_data > i_n) || r_used[i_wr_data];

  // The sticky flag survives the rest of the request; the mask is marked even for bad beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
      r_used <= '0;
      r_bad  <= 1'b0;
    end else if (i_clr) begin
      r_used <= '0;
      r_bad  <= 1'b0;
    end else if (i_wr_en) begin
      r_buf[i_wr_idx]   <= i_wr_data;
      r_used[i_wr_data] <= 1'b1;
      if (w_bad_beat) begin
        r_bad <= 1'b1;
      end
    end
  end

  assign o_rd_data = r_buf[i_rd_idx];
  assign o_bad     = r_bad;

endmodule

// File: rtl/train_feeder.sv
// Host-facing front end for Train: collects and validates one order request, replays it as a
// burst, then returns Train's verdict (or an error code) as a single response pulse.
module train_feeder
  import train_pkg::*;
#(
  parameter int MAX_CAR = 10,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [CAR_W-1:0] i_s_data,
  output logic             o_train_in_valid,
  output logic [CAR_W-1:0] o_train_data,
  input  logic             i_train_out_valid,
  input  logic             i_train_result,
  output logic             o_resp_valid,
  output logic             o_resp_result,
  output logic [1:0]       o_resp_err
);

  localparam logic [CAR_W-1:0] MAX_N = CAR_W'(MAX_CAR);
  localparam logic [7:0]       TMO   = 8'(TIMEOUT);

  state_t           r_state;
  logic [CAR_W-1:0] r_n;
  logic [CAR_W-1:0] r_idx;
  logic [CAR_W-1:0] r_cnt;
  logic [7:0]       r_wait;
  logic             r_s_ready;
  logic             r_train_in_valid;
  logic [CAR_W-1:0] r_train_data;
  logic             r_resp_valid;
  logic             r_resp_result;
  err_t             r_resp_err;

  logic             w_accept;
  logic             w_cnt_bad;
  logic             w_last;
  logic             w_clr;
  logic             w_wr_en;
  logic [CAR_W-1:0] w_rd_data;
  logic             w_bad;

  assign w_accept  = i_s_valid && r_s_ready;
  assign w_cnt_bad = (i_s_data == '0) || (i_s_data > MAX_N);
  assign w_last    = (r_idx == (r_n - 4'd1));
  assign w_clr     = (r_state == IDLE) && w_accept && !w_cnt_bad;
  assign w_wr_en   = (r_state == LOAD) && w_accept;

  train_order_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (i_s_data),
    .i_n       (r_n),
    .i_rd_idx  (r_cnt),
    .o_rd_data (w_rd_data),
    .o_bad     (w_bad)
  );

  // Any transition into RESP loads the response registers, so resp_valid is high while in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_n              <= '0;
      r_idx            <= '0;
      r_cnt            <= '0;
      r_wait           <= '0;
      r_s_ready        <= 1'b0;
      r_train_in_valid <= 1'b0;
      r_train_data     <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_result    <= 1'b0;
      r_resp_err       <= ERR_OK;
    end else begin
      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            if (w_cnt_bad) begin
              r_s_ready     <= 1'b0;
              r_resp_valid  <= 1'b1;
              r_resp_result <= 1'b0;
              r_resp_err    <= ERR_CNT;
              r_state       <= RESP;
            end else begin
              r_n     <= i_s_data;
              r_idx   <= '0;
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_idx <= r_idx + 4'd1;
            if (w_last) begin
              r_s_ready <= 1'b0;
              r_state   <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_bad) begin
            r_resp_valid  <= 1'b1;
            r_resp_result <= 1'b0;
            r_resp_err    <= ERR_ORD;
            r_state       <= RESP;
          end else begin
            r_train_in_valid <= 1'b1;
            r_train_data     <= r_n;
            r_cnt            <= '0;
            r_state          <= SEND;
          end
        end
        SEND: begin
          // The count beat went out on entry; r_cnt then walks the buffer in arrival order.
          if (r_cnt == r_n) begin
            r_train_in_valid <= 1'b0;
            r_train_data     <= '0;
            r_wait           <= '0;
            r_state          <= WAIT;
          end else begin
            r_train_data <= w_rd_data;
            r_cnt        <= r_cnt + 4'd1;
          end
        end
        WAIT: begin
          if (i_train_out_valid) begin
            r_resp_valid  <= 1'b1;
            r_resp_result <= i_train_result;
            r_resp_err    <= ERR_OK;
            r_state       <= RESP;
          end else if (r_wait >= TMO) begin
            r_resp_valid  <= 1'b1;
            r_resp_result <= 1'b0;
            r_resp_err    <= ERR_TMO;
            r_state       <= RESP;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        RESP: begin
          r_resp_valid  <= 1'b0;
          r_resp_result <= 1'b0;
          r_resp_err    <= ERR_OK;
          r_state       <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_s_ready        = r_s_ready;
  assign o_train_in_valid = r_train_in_valid;
  assign o_train_data     = r_train_data;
  assign o_resp_valid     = r_resp_valid;
  assign o_resp_result    = r_resp_result;
  assign o_resp_err       = r_resp_err;

endmodule

// File: tb/tb_train_feeder.sv
// Randomized bench for train_feeder: a request-level reference model predicts the burst and
// response for each order request, with a stub Train answering after a chosen delay.
module tb_train_feeder;

  localparam int MAX_CAR = 10;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_s_valid = 1'b0;
  logic       o_s_ready;
  logic [3:0] i_s_data = 4'd0;
  logic       o_train_in_valid;
  logic [3:0] o_train_data;
  logic       i_train_out_valid = 1'b0;
  logic       i_train_result = 1'b0;
  logic       o_resp_valid;
  logic       o_resp_result;
  logic [1:0] o_resp_err;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int lastAccept = 0;
  int burstStart = 0;
  int burstEnd = 0;
  logic prevInValid = 1'b0;
  int burstQ[$];
  int respErrQ[$];
  int respResQ[$];
  int respCycleQ[$];

  train_feeder #(.MAX_CAR(MAX_CAR), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_s_valid         (i_s_valid),
    .o_s_ready         (o_s_ready),
    .i_s_data          (i_s_data),
    .o_train_in_valid  (o_train_in_valid),
    .o_train_data      (o_train_data),
    .i_train_out_valid (i_train_out_valid),
    .i_train_result    (i_train_result),
    .o_resp_valid      (o_resp_valid),
    .o_resp_result     (o_resp_result),
    .o_resp_err        (o_resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Passive monitor: records every burst beat and every response pulse with its cycle stamp.
  always @(negedge clk) begin
    if (o_train_in_valid) begin
      if (!prevInValid) burstStart <= cycle;
      burstQ.push_back(int'(o_train_data));
    end else if (prevInValid) begin
      burstEnd <= cycle;
    end
    prevInValid <= o_train_in_valid;
    if (o_resp_valid) begin
      respErrQ.push_back(int'(o_resp_err));
      respResQ.push_back(int'(o_resp_result));
      respCycleQ.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendBeat(input int value);
    bit rdy;
    int guard;
    tick($urandom_range(0, 2));
    i_s_valid = 1'b1;
    i_s_data  = value[3:0];
    rdy = 1'b0;
    guard = 0;
    while (!rdy && guard < 60) begin
      @(negedge clk);
      rdy = o_s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    i_s_valid = 1'b0;
    i_s_data  = 4'd0;
    if (!rdy) checkOutput("beatAccept", 0, 1);
    else lastAccept = cycle;
  endtask

  task automatic makePerm(input int n, output int order[16]);
    int j;
    int t;
    for (int i = 0; i < 16; i++) order[i] = 0;
    for (int i = 0; i < n; i++) order[i] = i + 1;
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
  endtask

  // One full host request, with the stub Train answering `delay` cycles after the burst ends.
  task automatic applyStimulus(input string name, input int n, input int order[16],
                               input bit answer, input bit result, input int delay);
    int burstBase;
    int respBase;
    int expErr;
    int guard;
    int ovCycle;
    int expBurst[$];
    bit seen[16];
    burstBase = burstQ.size();
    respBase  = respErrQ.size();
    ovCycle   = 0;

    expErr = 0;
    if (n < 1 || n > MAX_CAR) begin
      expErr = 1;
    end else begin
      for (int i = 0; i < 16; i++) seen[i] = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (order[i] < 1 || order[i] > n || seen[order[i] & 15]) expErr = 2;
        seen[order[i] & 15] = 1'b1;
      end
    end
    if (expErr == 0) begin
      expBurst.push_back(n);
      for (int i = 0; i < n; i++) expBurst.push_back(order[i]);
      if (!answer) expErr = 3;
    end

    sendBeat(n);
    if (n >= 1 && n <= MAX_CAR) begin
      for (int i = 0; i < n; i++) sendBeat(order[i]);
    end

    if (expBurst.size() > 0) begin
      guard = 0;
      while (!(burstQ.size() > burstBase && !o_train_in_valid) && guard < 40) begin
        tick(1);
        guard++;
      end
      checkOutput($sformatf("%s.burstDone", name), int'(guard < 40), 1);
      if (answer) begin
        tick(delay);
        i_train_out_valid = 1'b1;
        i_train_result    = result;
        ovCycle           = cycle;
        tick(1);
        i_train_out_valid = 1'b0;
        i_train_result    = 1'b0;
      end
    end

    guard = 0;
    while (respErrQ.size() == respBase && guard < TIMEOUT + 40) begin
      tick(1);
      guard++;
    end
    tick(4);

    checkOutput($sformatf("%s.burstLen", name), burstQ.size() - burstBase, expBurst.size());
    for (int i = 0; i < expBurst.size(); i++) begin
      if (burstBase + i < burstQ.size())
        checkOutput($sformatf("%s.beat%0d", name, i), burstQ[burstBase + i], expBurst[i]);
    end
    if (expBurst.size() > 0)
      checkOutput($sformatf("%s.burstLatency", name), burstStart - lastAccept, 1);
    checkOutput($sformatf("%s.respCount", name), respErrQ.size() - respBase, 1);
    if (respErrQ.size() > respBase) begin
      checkOutput($sformatf("%s.respErr", name), respErrQ[respBase], expErr);
      checkOutput($sformatf("%s.respResult", name), respResQ[respBase],
                  (expErr == 0) ? int'(result) : 0);
      if (expErr == 0)
        checkOutput($sformatf("%s.respLatency", name), respCycleQ[respBase] - ovCycle, 1);
      if (expErr == 3)
        checkOutput($sformatf("%s.timeoutWindow", name),
                    int'((respCycleQ[respBase] - burstEnd >= TIMEOUT) &&
                         (respCycleQ[respBase] - burstEnd <= TIMEOUT + 2)), 1);
    end
    checkOutput($sformatf("%s.readyIdle", name), int'(o_s_ready), 1);
    checkOutput($sformatf("%s.dataIdle", name), int'(o_train_data), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ord[16];
    int n;
    int kind;
    int pos;
    int guard;
    int respBase;

    #1 rst_n = 1'b0;
    tick(3);
    checkOutput("resetOutputs",
                int'({o_s_ready, o_train_in_valid, o_train_data, o_resp_valid, o_resp_result, o_resp_err}), 0);
    rst_n = 1'b1;
    tick(1);
    checkOutput("readyAfterReset", int'(o_s_ready), 1);

    ord = '{default: 0}; ord[0] = 3; ord[1] = 2; ord[2] = 1;
    applyStimulus("t1", 3, ord, 1'b1, 1'b1, 10);
    ord = '{default: 0}; ord[0] = 3; ord[1] = 1; ord[2] = 2;
    applyStimulus("t2", 3, ord, 1'b1, 1'b0, 4);
    ord = '{default: 0};
    applyStimulus("t3zero", 0, ord, 1'b1, 1'b1, 0);
    applyStimulus("t3big", 11, ord, 1'b1, 1'b1, 0);
    ord = '{default: 0}; ord[0] = 2; ord[1] = 2; ord[2] = 1; ord[3] = 4;
    applyStimulus("t4dup", 4, ord, 1'b1, 1'b1, 0);
    ord = '{default: 0}; ord[0] = 1; ord[1] = 5; ord[2] = 2; ord[3] = 3;
    applyStimulus("t4range", 4, ord, 1'b1, 1'b1, 0);
    ord = '{default: 0}; ord[0] = 2; ord[1] = 1;
    applyStimulus("t5timeout", 2, ord, 1'b0, 1'b0, 0);

    respBase = respErrQ.size();
    i_train_out_valid = 1'b1;
    i_train_result    = 1'b1;
    tick(1);
    i_train_out_valid = 1'b0;
    i_train_result    = 1'b0;
    tick(5);
    checkOutput("strayOutValidNoResp", respErrQ.size() - respBase, 0);
    checkOutput("strayOutValidReady", int'(o_s_ready), 1);

    ord = '{default: 0}; ord[0] = 1;
    applyStimulus("edgeN1", 1, ord, 1'b1, 1'b1, 0);
    makePerm(MAX_CAR, ord);
    applyStimulus("edgeNmax", MAX_CAR, ord, 1'b1, 1'b0, 7);

    // Reset in the middle of a burst must abort it silently.
    respBase = respErrQ.size();
    pos = burstQ.size();
    makePerm(4, ord);
    sendBeat(4);
    for (int i = 0; i < 4; i++) sendBeat(ord[i]);
    guard = 0;
    while (burstQ.size() < pos + 2 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t6burstStarted", int'(guard < 40), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6inValidDrop", int'(o_train_in_valid), 0);
    checkOutput("t6respQuiet", int'(o_resp_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(10);
    checkOutput("t6noResp", respErrQ.size() - respBase, 0);
    makePerm(5, ord);
    applyStimulus("t6after", 5, ord, 1'b1, 1'b1, 3);

    for (int r = 0; r < 12; r++) begin
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_CAR + 1, 15);
        ord = '{default: 0};
        applyStimulus($sformatf("rnd%0d", r), n, ord, 1'b1, 1'b1, 0);
      end else if (kind == 2) begin
        n = $urandom_range(2, MAX_CAR);
        makePerm(n, ord);
        pos = $urandom_range(0, n - 1);
        case ($urandom_range(0, 2))
          0: ord[pos] = 0;
          1: ord[pos] = $urandom_range(n + 1, 15);
          default: ord[pos] = ord[(pos + 1) % n];
        endcase
        applyStimulus($sformatf("rnd%0d", r), n, ord, 1'b1, 1'b1, 0);
      end else begin
        n = $urandom_range(1, MAX_CAR);
        makePerm(n, ord);
        applyStimulus($sformatf("rnd%0d", r), n, ord, 1'b1, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 20));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
